// File: rtl/tube_dma_ctrl.sv
// tube_dma_ctrl: parasite-side DMA engine moving bytes between tube_ula register 3 and memory.
// Define TUBE_DMA_IRQ_EN to build the sticky completion interrupt; otherwise DMAIRQ is tied low.
module tube_dma_ctrl (
  input  logic        HO2,
  input  logic        HRST,
  input  logic        START,
  input  logic        DIR,
  input  logic [15:0] BASE,
  input  logic [15:0] LEN,
  input  logic        ABORT,
  input  logic        DRQ,
  output logic        DACK,
  output logic        PNRDS,
  output logic        PNWDS,
  input  logic [7:0]  PDIN,
  output logic [7:0]  PDOUT,
  output logic [15:0] MADDR,
  output logic        MRE,
  input  logic [7:0]  MRDATA,
  output logic        MWE,
  output logic [7:0]  MWDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] REMAIN,
  output logic        DMAIRQ
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_ACK,
    ST_STROBE,
    ST_MEM,
    ST_REC1,
    ST_REC2,
    ST_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] remain_q, remain_d;
  logic        dir_q, dir_d;
  logic        dack_q, dack_d;
  logic        pnrds_q, pnrds_d;
  logic        pnwds_q, pnwds_d;
  logic [7:0]  pdout_q, pdout_d;
  logic [15:0] maddr_q, maddr_d;
  logic        mre_q, mre_d;
  logic        mwe_q, mwe_d;
  logic [7:0]  mwdata_q, mwdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    pdout_d  = pdout_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          addr_d   = BASE;
          remain_d = LEN;
          dir_d    = DIR;
          state_d  = (LEN == 16'd0) ? ST_FIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (DRQ) begin
          state_d = dir_q ? ST_FETCH : ST_ACK;
        end
      end
      ST_FETCH: state_d = ST_ACK;
      ST_ACK: begin
        if (dir_q) begin
          pdout_d = MRDATA;
        end
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (dir_q) begin
          state_d = ST_REC1;
        end else begin
          mwdata_d = PDIN;
          state_d  = ST_MEM;
        end
      end
      ST_MEM: state_d = ST_REC1;
      ST_REC1: begin
        remain_d = remain_q - 16'd1;
        addr_d   = addr_q + 16'd1;
        state_d  = ST_REC2;
      end
      ST_REC2: state_d = (remain_q == 16'd0) ? ST_FIN : ST_WAIT;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so each flop shows the state it belongs to.
    if ((state_d == ST_FETCH) || (state_d == ST_MEM)) begin
      maddr_d = addr_q;
    end
    dack_d  = (state_d == ST_ACK) || (state_d == ST_STROBE);
    pnrds_d = !((state_d == ST_STROBE) && !dir_q);
    pnwds_d = !((state_d == ST_STROBE) && dir_q);
    mre_d   = (state_d == ST_FETCH);
    mwe_d   = (state_d == ST_MEM);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
  end

  always_ff @(posedge HO2 or negedge HRST) begin
    if (!HRST) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'd0;
      remain_q <= 16'd0;
      dir_q    <= 1'b0;
      dack_q   <= 1'b0;
      pnrds_q  <= 1'b1;
      pnwds_q  <= 1'b1;
      pdout_q  <= 8'd0;
      maddr_q  <= 16'd0;
      mre_q    <= 1'b0;
      mwe_q    <= 1'b0;
      mwdata_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      dack_q   <= dack_d;
      pnrds_q  <= pnrds_d;
      pnwds_q  <= pnwds_d;
      pdout_q  <= pdout_d;
      maddr_q  <= maddr_d;
      mre_q    <= mre_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef TUBE_DMA_IRQ_EN
  logic irq_q, irq_d;

  // Sticky until software starts the next transfer; a zero-length start sets it straight away.
  always_comb begin
    irq_d = irq_q;
    if ((state_q == ST_IDLE) && START) begin
      irq_d = 1'b0;
    end
    if (state_d == ST_FIN) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge HO2 or negedge HRST) begin
    if (!HRST) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign DMAIRQ = irq_q;
`else
  assign DMAIRQ = 1'b0;
`endif

  assign DACK   = dack_q;
  assign PNRDS  = pnrds_q;
  assign PNWDS  = pnwds_q;
  assign PDOUT  = pdout_q;
  assign MADDR  = maddr_q;
  assign MRE    = mre_q;
  assign MWE    = mwe_q;
  assign MWDATA = mwdata_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign REMAIN = remain_q;

endmodule

// File: tb/tb_tube_dma_ctrl.sv
// Self-checking bench for tube_dma_ctrl: directed scenarios plus randomized transfers
// checked cycle by cycle against a timing model derived from the byte-cycle arithmetic.
module tb_tube_dma_ctrl;

`ifdef TUBE_DMA_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        HO2;
  logic        HRST;
  logic        START;
  logic        DIR;
  logic [15:0] BASE;
  logic [15:0] LEN;
  logic        ABORT;
  logic        DRQ;
  logic        DACK;
  logic        PNRDS;
  logic        PNWDS;
  logic [7:0]  PDIN;
  logic [7:0]  PDOUT;
  logic [15:0] MADDR;
  logic        MRE;
  logic [7:0]  MRDATA;
  logic        MWE;
  logic [7:0]  MWDATA;
  logic        BUSY;
  logic        DONE;
  logic [15:0] REMAIN;
  logic        DMAIRQ;

  int checks;
  int errors;

  logic [7:0] mem [0:65535];
  logic [7:0] pdin_bytes [0:15];

  tube_dma_ctrl dut (
    .HO2(HO2), .HRST(HRST), .START(START), .DIR(DIR), .BASE(BASE), .LEN(LEN),
    .ABORT(ABORT), .DRQ(DRQ), .DACK(DACK), .PNRDS(PNRDS), .PNWDS(PNWDS),
    .PDIN(PDIN), .PDOUT(PDOUT), .MADDR(MADDR), .MRE(MRE), .MRDATA(MRDATA),
    .MWE(MWE), .MWDATA(MWDATA), .BUSY(BUSY), .DONE(DONE), .REMAIN(REMAIN),
    .DMAIRQ(DMAIRQ)
  );

  initial begin
    HO2 = 1'b0;
    forever #5 HO2 = ~HO2;
  end

  // Synchronous-read memory: data for an MRE cycle appears on the following cycle.
  initial MRDATA = 8'd0;
  always @(posedge HO2) begin
    if (MRE) MRDATA <= mem[MADDR];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] reset_vector();
    return {8'd0, DACK, PNRDS, PNWDS, PDOUT, MADDR, MRE, MWE, MWDATA, BUSY, DONE, REMAIN, DMAIRQ};
  endfunction

  localparam logic [63:0] RESET_EXP = {8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0,
                                       1'b0, 1'b0, 16'd0, 1'b0};

  // Byte i occupies cycles 1+6i .. 6+6i after the START edge: WAIT, then the direction's
  // three bus phases, then two bookkeeping cycles. FIN follows the last byte.
  task automatic applyStimulus(input bit dir, input logic [15:0] base, input int len,
                               input int ka, input bit spurious, input int maxk);
    int j, nb, end_k, i, p, completed;
    bit aborted;
    logic e_dack, e_rds, e_wds, e_mre, e_mwe, e_busy, e_done, e_irq;
    logic [15:0] e_addr;
    aborted = 1'b0;
    nb = len;
    if (ka > 0) begin
      j = (ka + 4) / 6;
      if (j < len) begin
        aborted = 1'b1;
        nb = j;
      end
    end
    end_k = aborted ? (2 + 6 * nb) : (6 * len + 2);
    START = 1'b1;
    DIR   = dir;
    BASE  = base;
    LEN   = len[15:0];
    ABORT = 1'b0;
    PDIN  = pdin_bytes[0];
    for (int k = 1; k <= end_k && k <= maxk; k++) begin
      @(posedge HO2);
      #1;
      START = 1'b0;
      if (spurious && k == 3 && end_k > 4) begin
        START = 1'b1;
        BASE  = ~base;
        LEN   = 16'd9;
        DIR   = ~dir;
      end
      if (ka > 0 && k == ka) ABORT = 1'b1;
      i = (k - 1) / 6;
      p = (k - 1) % 6;
      e_addr = base + 16'(i);
      e_dack = 1'b0; e_rds = 1'b1; e_wds = 1'b1; e_mre = 1'b0; e_mwe = 1'b0; e_done = 1'b0;
      e_busy = (k < end_k);
      if (i < nb) begin
        if (!dir) begin
          e_dack = (p == 1) || (p == 2);
          e_rds  = !(p == 2);
          e_mwe  = (p == 3);
        end else begin
          e_mre  = (p == 1);
          e_dack = (p == 2) || (p == 3);
          e_wds  = !(p == 3);
        end
      end
      if (!aborted && k == 6 * len + 1) e_done = 1'b1;
      completed = (k / 6 < nb) ? k / 6 : nb;
      e_irq = IRQ_EN && !aborted && (k >= 6 * len + 1);
      checkOutput($sformatf("ctl k=%0d dir=%0d len=%0d", k, dir, len),
                  {56'd0, DACK, PNRDS, PNWDS, MRE, MWE, BUSY, DONE, DMAIRQ},
                  {56'd0, e_dack, e_rds, e_wds, e_mre, e_mwe, e_busy, e_done, e_irq});
      checkOutput($sformatf("remain k=%0d", k), {48'd0, REMAIN}, 64'(len - completed));
      if (e_mwe) begin
        checkOutput($sformatf("wr addr k=%0d", k), {48'd0, MADDR}, {48'd0, e_addr});
        checkOutput($sformatf("wr data k=%0d", k), {56'd0, MWDATA}, {56'd0, pdin_bytes[i % 16]});
      end
      if (e_mre) begin
        checkOutput($sformatf("rd addr k=%0d", k), {48'd0, MADDR}, {48'd0, e_addr});
      end
      if (!e_wds) begin
        checkOutput($sformatf("pdout k=%0d", k), {56'd0, PDOUT}, {56'd0, mem[e_addr]});
      end
      PDIN = pdin_bytes[i % 16];
    end
    ABORT = 1'b0;
    START = 1'b0;
  endtask

  initial begin
    logic [15:0] rbase;
    int rlen, rka;
    bit rdir, rsp;
    checks = 0;
    errors = 0;
    HRST = 1'b0; START = 1'b0; DIR = 1'b0; BASE = 16'd0; LEN = 16'd0;
    ABORT = 1'b0; DRQ = 1'b1; PDIN = 8'd0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3);
    for (int b = 0; b < 16; b++) pdin_bytes[b] = 8'(b * 17 + 1);

    repeat (2) @(posedge HO2);
    #1;
    checkOutput("reset values", reset_vector(), RESET_EXP);
    HRST = 1'b1;
    @(posedge HO2);
    #1;

    $display("[TB] ULA to memory, three bytes at 0x1000");
    pdin_bytes[0] = 8'hA1; pdin_bytes[1] = 8'hB2; pdin_bytes[2] = 8'hC3;
    applyStimulus(1'b0, 16'h1000, 3, 0, 1'b0, 1000);

    $display("[TB] memory to ULA with address wrap");
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'h3C;
    applyStimulus(1'b1, 16'hFFFF, 2, 0, 1'b0, 1000);
    checkOutput("wrap last pdout", {56'd0, PDOUT}, 64'h3C);
    checkOutput("wrap last maddr", {48'd0, MADDR}, 64'h0000);

    $display("[TB] empty transfer then a normal one");
    applyStimulus(1'b0, 16'h4444, 0, 0, 1'b0, 1000);
    applyStimulus(1'b0, 16'h0100, 1, 0, 1'b0, 1000);

    $display("[TB] abort during second byte strobe");
    applyStimulus(1'b0, 16'h2000, 5, 9, 1'b0, 1000);
    checkOutput("abort remain", {48'd0, REMAIN}, 64'd3);

    $display("[TB] DRQ held low after START");
    DRQ = 1'b0;
    pdin_bytes[0] = 8'h77;
    PDIN = 8'h77;
    START = 1'b1; DIR = 1'b0; BASE = 16'h2222; LEN = 16'd1;
    @(posedge HO2);
    #1;
    START = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("stall c=%0d", c), {62'd0, DACK, BUSY}, 64'b01);
      @(posedge HO2);
      #1;
    end
    DRQ = 1'b1;
    @(posedge HO2); #1;
    checkOutput("stall ack", {61'd0, DACK, PNRDS, MWE}, 64'b110);
    @(posedge HO2); #1;
    checkOutput("stall strobe", {61'd0, DACK, PNRDS, MWE}, 64'b100);
    @(posedge HO2); #1;
    checkOutput("stall mem", {39'd0, DACK, MWE, MADDR, MWDATA}, {39'd0, 1'b0, 1'b1, 16'h2222, 8'h77});
    repeat (3) @(posedge HO2);
    #1;
    checkOutput("stall done", {62'd0, DONE, BUSY}, 64'b11);
    @(posedge HO2); #1;
    checkOutput("stall idle", {47'd0, DONE, BUSY, REMAIN}, 64'd0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 14; t++) begin
      rdir  = 1'($urandom);
      rlen  = $urandom_range(0, 6);
      rbase = ($urandom % 4 == 0) ? 16'hFFFD : 16'($urandom);
      rka   = (rlen > 0 && $urandom % 2 == 1) ? $urandom_range(1, 6 * rlen + 1) : 0;
      rsp   = 1'($urandom);
      for (int b = 0; b < 16; b++) pdin_bytes[b] = 8'($urandom);
      for (int b = 0; b < rlen; b++) mem[rbase + 16'(b)] = 8'($urandom);
      applyStimulus(rdir, rbase, rlen, rka, rsp, 1000);
    end

    $display("[TB] reset in the middle of a transfer");
    applyStimulus(1'b0, 16'h3000, 4, 0, 1'b0, 15);
    checkOutput("pre-reset strobe", {63'd0, PNRDS}, 64'd0);
    #2;
    HRST = 1'b0;
    #1;
    checkOutput("async reset", reset_vector(), RESET_EXP);
    #2;
    HRST = 1'b1;
    @(posedge HO2);
    #1;
    checkOutput("post-reset idle", reset_vector(), RESET_EXP);
    applyStimulus(1'b1, 16'h0010, 2, 0, 1'b0, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_dma_ctrl.md
# tube_dma_ctrl

Parasite-side DMA engine that consumes the tube_ula DMA request and moves bytes between tube_ula register 3 and parasite memory without CPU involvement. It sits directly on the parasite side of tube_ula: it watches DRQ, drives DACK and the PNRDS/PNWDS strobes, and presents a simple single-port memory interface. Software programs base, length and direction, then pulses START.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- HO2  in  1  system clock; all logic on rising edge
- HRST  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse; latch BASE/LEN/DIR and begin
- DIR  in  1  0 = ULA→memory (PNRDS cycles), 1 = memory→ULA (PNWDS cycles)
- BASE  in  16  first memory address
- LEN  in  16  byte count; 0 = empty transfer
- ABORT  in  1  level; stop after the byte in progress
- DRQ  in  1  DMA request from tube_ula
- DACK  out  1  DMA acknowledge to tube_ula; selects register 3
- PNRDS  out  1  parasite read strobe, active-low
- PNWDS  out  1  parasite write strobe, active-low
- PDIN  in  8  data from tube_ula (its PDOUT)
- PDOUT  out  8  data to tube_ula (its PDIN)
- MADDR  out  16  memory address
- MRE  out  1  memory read enable; MRDATA valid the following cycle
- MRDATA  in  8  memory read data
- MWE  out  1  memory write enable, one cycle
- MWDATA  out  8  memory write data
- BUSY  out  1  high from accepted START until return to IDLE
- DONE  out  1  one-cycle pulse on normal completion
- REMAIN  out  16  bytes not yet transferred
- DMAIRQ  out  1  completion interrupt (see Configuration)

## Operation
- States: IDLE, WAIT, FETCH, ACK, STROBE, MEM, REC1, REC2, FIN.
- IDLE: START latches ADDR←BASE, REMAIN←LEN, DIR; goes to FIN if LEN=0, else WAIT. START while BUSY ignored.
- WAIT: ABORT high → IDLE. DRQ high → MEM-less path per DIR: DIR=0 → ACK; DIR=1 → FETCH. Else stay.
- DIR=0: ACK (DACK=1) → STROBE (DACK=1, PNRDS=0, capture PDIN at cycle end) → MEM (DACK=0, MWE=1, MADDR=ADDR, MWDATA=captured) → REC1.
- DIR=1: FETCH (MRE=1, MADDR=ADDR) → ACK (DACK=1, PDOUT←MRDATA) → STROBE (DACK=1, PNWDS=0, PDOUT held) → REC1.
- REC1: REMAIN←REMAIN−1, ADDR←ADDR+1 (16-bit wrap, FFFF→0000). REC2: idle cycle letting tube_ula deassert DRQ; → FIN if REMAIN=0, else WAIT.
- FIN: DONE=1 for this cycle, → IDLE.
- ABORT sampled only in WAIT; a byte past WAIT always completes. Abort gives no DONE; REMAIN retains untransferred count.
- ABORT and START together in IDLE: START accepted (ABORT ignored in IDLE).
- PNRDS and PNWDS never low in the same cycle; strobes low only while DACK=1.

## Timing
- Reset (HRST low, async): state IDLE; DACK=0, PNRDS=1, PNWDS=1, PDOUT=0, MADDR=0, MRE=0, MWE=0, MWDATA=0, BUSY=0, DONE=0, REMAIN=0, DMAIRQ=0. Reset mid-transfer abandons it immediately; strobes release asynchronously.
- START→first DACK: DIR=0 2 cycles (WAIT, ACK), DIR=1 3 cycles, if DRQ already high.
- DRQ held high: exactly 6 cycles per byte in either direction.
- DONE asserts the cycle after REC2 of the last byte; BUSY falls the cycle after DONE. LEN=0: DONE 1 cycle after START, no bus activity.
- All outputs registered.

## Configuration
- TUBE_DMA_IRQ_EN defined: DMAIRQ sets on DONE, stays set until the next accepted START (set wins if simultaneous in same cycle is impossible; START clears).
- Not defined: DMAIRQ tied to 0, no IRQ flop.

## Test plan
- Reset mid-transfer, DIR=0, LEN=4, after 2 bytes → all outputs at reset values immediately, PNRDS=1 asynchronously.
- DIR=0, BASE=0x1000, LEN=3, DRQ high, PDIN=0xA1,0xB2,0xC3 → MWE writes 0x1000/A1, 0x1001/B2, 0x1002/C3, 6 cycles apart; DONE once; REMAIN=0.
- DIR=1, BASE=0xFFFF, LEN=2, memory 0xFFFF=0x5A, 0x0000=0x3C → PNWDS cycles with PDOUT 0x5A then 0x3C; address wraps to 0x0000.
- DRQ low 10 cycles after START → stays in WAIT, no DACK; DRQ high → byte proceeds normally.
- LEN=0 → DONE 1 cycle after START, no DACK/MRE/MWE; with TUBE_DMA_IRQ_EN DMAIRQ=1 until next START.
- LEN=5, ABORT raised during byte 2 STROBE → byte 2 completes, IDLE with REMAIN=3, no DONE, DMAIRQ stays 0.
